// File: rtl/pipe_reg_pkg.sv
// Shared types, defaults and helper functions for the pipe_reg ready/valid delay line.
package pipe_reg_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Legal configuration: at least one stage of at least one bit.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Handshake bus of pipe_reg: producer side, consumer side, flush and occupancy.
// master = the environment around the pipe, slave = the pipe itself.
interface pipe_reg_if
    import pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) ();

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output clr,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  clr,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: a valid flag plus a data word that only loads valid words.
module pipe_reg_stage
    import pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    // Valid follows the source on load, flush wins; data holds unless a valid word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else begin
            if (clr) begin
                v_out <= 1'b0;
            end else if (load) begin
                v_out <= v_in;
            end
            if (!clr && load && v_in) begin
                d_out <= d_in;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Fixed-latency ready/valid register pipeline with flush and occupancy count.
// Build option PIPE_REG_BUBBLE_COLLAPSE_EN: when defined, each stage advances
// independently so bubbles are squeezed out under backpressure; when undefined,
// all stages shift together on a single global enable.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    pipe_reg_if.slave bus
);

    localparam int unsigned CNT_W  = cnt_w(DEPTH);
    localparam bit          CFG_OK = cfg_ok(WIDTH, DEPTH);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("pipe_reg: WIDTH and DEPTH must both be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             in_rdy_c;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;

    // Each stage is fed by the previous one; stage 0 is fed by the producer.
    always_comb begin
        src_v = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            src_d[k] = '0;
        end
        src_v[0] = bus.in_valid;
        src_d[0] = bus.in_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
            src_v[k] = v[k-1];
            src_d[k] = d[k-1];
        end
    end

`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    // adv[k]: the word in stage k may move on (next stage empty or itself moving).
    logic [DEPTH-1:0] adv;

    // Advance chain, evaluated from the output end back toward the input.
    always_comb begin
        logic acc;
        adv = '0;
        acc = bus.out_ready | ~v[DEPTH-1];
        adv[DEPTH-1] = acc;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            acc    = acc | ~v[k+1];
            adv[k] = acc;
        end
    end

    // A stage loads when it is empty or its current word is leaving.
    always_comb begin
        in_rdy_c = ~rst & ~bus.clr & (~v[0] | adv[0]);
        load     = '0;
        load[0]  = in_rdy_c;
        for (int k = 1; k < int'(DEPTH); k++) begin
            load[k] = ~v[k] | adv[k];
        end
    end
`else
    logic en_c;

    // Whole pipe shifts as one unit whenever the output stage can drain.
    always_comb begin
        en_c     = bus.out_ready | ~v[DEPTH-1];
        in_rdy_c = ~rst & ~bus.clr & en_c;
        load     = {DEPTH{en_c}};
        load[0]  = in_rdy_c;
    end
`endif

    genvar gk;
    generate
        for (gk = 0; gk < int'(DEPTH); gk++) begin : g_stage
            pipe_reg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .load  (load[gk]),
                .clr   (bus.clr),
                .v_in  (src_v[gk]),
                .d_in  (src_d[gk]),
                .v_out (v[gk]),
                .d_out (d[gk])
            );
        end
    endgenerate

    // Next-cycle valid flags mirror the stage update so the count can be registered.
    always_comb begin
        v_nxt     = v;
        count_nxt = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (bus.clr) begin
                v_nxt[k] = 1'b0;
            end else if (load[k]) begin
                v_nxt[k] = src_v[k];
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            count_nxt = count_nxt + CNT_W'(v_nxt[k]);
        end
    end

    // Registered occupancy, always equal to the popcount of the stage valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign bus.in_ready  = in_rdy_c;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.count     = count_q;

endmodule
